lif_mux_array: RTL and testbench
================================

# lif_mux_array

Time-multiplexed array of leaky integrate-and-fire neurons sharing one update datapath. Per-neuron membrane potential, input current and refractory count live in internal register files. A round-robin scheduler updates one neuron per enabled cycle and emits a registered spike event with the neuron index. This block is the parametrised, multi-neuron successor to the single-neuron LIF and sits between the current-injection logic and the spike-event consumer.

## Interface
- `N_NEURONS`, default 4: neurons in the array; ≥2.
- `WIDTH`, default 8: width of potential, current and threshold; unsigned.
- `LEAK_SHIFT`, default 1: leak is potential >> LEAK_SHIFT per update; range 0..WIDTH-1.
- `REFRAC_CYCLES`, default 2: updates a neuron is held after spiking; range 0..15.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scheduler advance; when low, nothing updates.
- `cur_we`  in  1  write strobe for the current register file.
- `cur_addr`  in  clog2(N_NEURONS)  neuron index to write; out-of-range writes are ignored.
- `cur_data`  in  WIDTH  current value; held until overwritten.
- `threshold`  in  WIDTH  spike threshold; sampled on every update.
- `spike_valid`  out  1  one-cycle pulse: the neuron just updated spiked.
- `spike_idx`  out  clog2(N_NEURONS)  index of the updated neuron; valid with `spike_valid`.
- `frame_done`  out  1  one-cycle pulse after neuron N_NEURONS-1 is updated.
- `state_out`  out  WIDTH  post-update potential of the neuron just processed.

## Operation
- Scheduler index `idx` counts 0..N_NEURONS-1 and wraps to 0. It advances only when `en` is high.
- Each enabled cycle updates neuron `idx`:
  - sum = cur[idx] + (v[idx] >> LEAK_SHIFT), computed at WIDTH+1 bits.
  - sum saturates to 2^WIDTH-1.
- Spike when the saturated sum ≥ `threshold`. On spike, v[idx] is written to 0. Otherwise v[idx] is written with the saturated sum.
- `threshold` = 0 makes the neuron spike on every non-refractory update.
- `cur_we` with the same index as `idx` in the same cycle: the update uses the old current, and the new value applies from the next update.
- Refractory behaviour (with the macro enabled):
  - A spike loads rc[idx] = REFRAC_CYCLES.
  - While rc[idx] > 0, an update writes v[idx] = 0, does not spike and decrements rc[idx].
- `en` low: `idx`, v, rc and the outputs' registered sources hold. Pulses deassert. `cur_we` is still honoured.
- Reset: all v, cur, rc = 0; `idx` = 0. Reset mid-frame abandons the frame with no `frame_done` pulse.

## Timing
- Outputs are registered. Results for the neuron updated in cycle t appear in cycle t+1.
- Each neuron is updated once every N_NEURONS enabled cycles.
- `frame_done` is asserted in the cycle after the update of neuron N_NEURONS-1.
- Reset values: `spike_valid`=0, `spike_idx`=0, `frame_done`=0, `state_out`=0.
- `state_out` shows 0 on a spike update and on refractory updates.
- There is no backpressure. The consumer must accept one event per cycle.

## Configuration
- `LIF_REFRACTORY_EN` defined: rc register file and refractory hold as described above.
- `LIF_REFRACTORY_EN` undefined: no rc storage, and `REFRAC_CYCLES` is ignored. A neuron can spike on the update immediately following its spike.

## Structure
- Package `lif_pkg` holds:
  - the index width function, clog2(N_NEURONS);
  - the saturating-add function;
  - the refractory counter width constant (4).
- Sub-module `lif_update` is the combinational single-neuron datapath.
  - Inputs: v, cur, rc, threshold.
  - Outputs: v_next, rc_next, spike.
- The top level owns the register files, the scheduler and the output registers.

## Test plan
All cases use defaults and count cycles from the first cycle with `rst`=0 and `en`=1.
- **Integration to spike:** cur[0]=64, others 0, threshold=127.
  - v0 runs 64, 96, 112, 120, 124, 126, 127.
  - The 7th update (cycle 24) spikes, giving `spike_valid`=1 and `spike_idx`=0 at cycle 25.
- **Saturation:** cur[2]=255, threshold=255.
  - The first update gives 255 and spikes: `spike_valid` at cycle 3 with `spike_idx`=2.
  - That update's `state_out` is 0.
- **Refractory:** cur[1]=255, threshold=200, macro enabled.
  - Spikes at cycles 2 and 14. The updates at cycles 5 and 9 are held.
  - With the macro disabled, spikes occur at cycles 2, 6, 10 and 14.
- **Write collision:** at cycle 4, set `cur_we` with addr 0 and data 100, while neuron 0 holds cur 0 and v 0.
  - `state_out` is 0 at cycle 5.
  - Neuron 0 reaches 100 at cycle 9.
- **`en` gating and frame:**
  - `frame_done` pulses at cycles 4 and 8.
  - Dropping `en` for 3 cycles at cycle 5 delays the next `frame_done` to cycle 11, with v unchanged across the gap.
- **Reset mid-frame:** assert `rst` at cycle 10 with nonzero v.
  - The next cycle shows all outputs at 0.
  - After release, `idx` restarts at 0 and integration restarts from 0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron array.
// Refractory storage is enabled by defining LIF_REFRACTORY_EN.
package lif_pkg;

    localparam int RC_W = 4;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Unsigned add of two operands, clamped to the largest w-bit value.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [64:0] sum;
        logic [64:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (65'd1 << w) - 65'd1;
        return (sum > max_v) ? max_v[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron leak/integrate/fire step.
// Refractory hold is compiled in only when LIF_REFRACTORY_EN is defined.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] cur,
    input  logic [RC_W-1:0]  rc,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] v_next,
    output logic [RC_W-1:0]  rc_next,
    output logic             spike
);

    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] sum_sat;

    assign leaked  = v >> LEAK_SHIFT;
    assign sum_sat = WIDTH'(sat_add(64'(cur), 64'(leaked), WIDTH));

    always_comb begin
        v_next  = sum_sat;
        rc_next = '0;
        spike   = 1'b0;
`ifdef LIF_REFRACTORY_EN
        if (rc != '0) begin
            v_next  = '0;
            rc_next = rc - RC_W'(1);
        end else if (sum_sat >= threshold) begin
            v_next  = '0;
            rc_next = RC_W'(REFRAC_CYCLES);
            spike   = 1'b1;
        end
`else
        if (sum_sat >= threshold) begin
            v_next = '0;
            spike  = 1'b1;
        end
`endif
    end

`ifndef LIF_REFRACTORY_EN
    logic unused_rc;
    assign unused_rc = ^{rc, RC_W'(REFRAC_CYCLES)};
`endif

endmodule

// File: rtl/lif_mux_array.sv
// Array of LIF neurons sharing one lif_update datapath via a round-robin scheduler.
// Define LIF_REFRACTORY_EN to add the per-neuron refractory counters.
module lif_mux_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = 4,
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          cur_we,
    input  logic [idx_w(N_NEURONS)-1:0]   cur_addr,
    input  logic [WIDTH-1:0]              cur_data,
    input  logic [WIDTH-1:0]              threshold,
    output logic                          spike_valid,
    output logic [idx_w(N_NEURONS)-1:0]   spike_idx,
    output logic                          frame_done,
    output logic [WIDTH-1:0]              state_out
);

    localparam int IDX_W = idx_w(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] v_q   [N_NEURONS];
    logic [WIDTH-1:0] v_d   [N_NEURONS];
    logic [WIDTH-1:0] cur_q [N_NEURONS];
    logic [WIDTH-1:0] cur_d [N_NEURONS];

    logic             spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0] spike_idx_q, spike_idx_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] state_out_q, state_out_d;

    logic [WIDTH-1:0] v_nxt;
    logic [RC_W-1:0]  rc_cur, rc_nxt;
    logic             spike;

    lif_update #(
        .WIDTH        (WIDTH),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRAC_CYCLES(REFRAC_CYCLES)
    ) u_update (
        .v        (v_q[idx_q]),
        .cur      (cur_q[idx_q]),
        .rc       (rc_cur),
        .threshold(threshold),
        .v_next   (v_nxt),
        .rc_next  (rc_nxt),
        .spike    (spike)
    );

`ifdef LIF_REFRACTORY_EN
    logic [RC_W-1:0] rc_q [N_NEURONS];
    logic [RC_W-1:0] rc_d [N_NEURONS];

    assign rc_cur = rc_q[idx_q];

    always_comb begin
        rc_d = rc_q;
        if (en) begin
            rc_d[idx_q] = rc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) rc_q[i] <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end
`else
    logic unused_rc_nxt;
    assign rc_cur        = '0;
    assign unused_rc_nxt = ^rc_nxt;
`endif

    // Current writes are independent of en; the update reads the pre-write value.
    always_comb begin
        idx_d         = idx_q;
        v_d           = v_q;
        cur_d         = cur_q;
        spike_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        spike_idx_d   = spike_idx_q;
        state_out_d   = state_out_q;
        if (cur_we && (int'(cur_addr) < N_NEURONS)) begin
            cur_d[cur_addr] = cur_data;
        end
        if (en) begin
            v_d[idx_q]    = v_nxt;
            idx_d         = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            spike_valid_d = spike;
            spike_idx_d   = idx_q;
            frame_done_d  = (idx_q == LAST_IDX);
            state_out_d   = v_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            frame_done_q  <= 1'b0;
            state_out_q   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]   <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            idx_q         <= idx_d;
            v_q           <= v_d;
            cur_q         <= cur_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            frame_done_q  <= frame_done_d;
            state_out_q   <= state_out_d;
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign frame_done  = frame_done_q;
    assign state_out   = state_out_q;

endmodule

// File: tb/tb_lif_mux_array.sv
// Directed self-checking bench for lif_mux_array at default parameters.
// Expectations adapt to whether LIF_REFRACTORY_EN is defined.
module tb_lif_mux_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cur_we;
    logic [1:0] cur_addr;
    logic [7:0] cur_data;
    logic [7:0] threshold;
    logic       spike_valid;
    logic [1:0] spike_idx;
    logic       frame_done;
    logic [7:0] state_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    lif_mux_array dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cur_we     (cur_we),
        .cur_addr   (cur_addr),
        .cur_data   (cur_data),
        .threshold  (threshold),
        .spike_valid(spike_valid),
        .spike_idx  (spike_idx),
        .frame_done (frame_done),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        en     = 1'b0;
        cur_we = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        cur_we   = 1'b1;
        cur_addr = addr;
        cur_data = data;
        step();
        cur_we = 1'b0;
    endtask

    task automatic start();
        en  = 1'b1;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        logic [7:0] integ_exp [6];
        int         spike_cyc [4];
        logic       exp_sv;
        integ_exp = '{8'd64, 8'd96, 8'd112, 8'd120, 8'd124, 8'd126};
        spike_cyc = '{2, 6, 10, 14};

        rst = 1'b1; en = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0; threshold = '0;

        // Reset values
        do_reset();
        check_eq("rst_spike_valid", 32'(spike_valid), 0);
        check_eq("rst_spike_idx", 32'(spike_idx), 0);
        check_eq("rst_frame_done", 32'(frame_done), 0);
        check_eq("rst_state_out", 32'(state_out), 0);

        // Integration to spike
        do_reset();
        threshold = 8'd127;
        wr(2'd0, 8'd64);
        start();
        for (int k = 0; k < 6; k++) begin
            run_to(4 * k + 1);
            check_eq("integ_v0", 32'(state_out), 32'(integ_exp[k]));
        end
        run_to(21);
        check_eq("integ_no_spike_early", 32'(spike_valid), 0);
        run_to(25);
        check_eq("integ_spike_valid", 32'(spike_valid), 1);
        check_eq("integ_spike_idx", 32'(spike_idx), 0);
        check_eq("integ_state_zero", 32'(state_out), 0);

        // Saturation
        do_reset();
        threshold = 8'd255;
        wr(2'd2, 8'd255);
        start();
        run_to(2);
        check_eq("sat_no_spike_n1", 32'(spike_valid), 0);
        run_to(3);
        check_eq("sat_spike_valid", 32'(spike_valid), 1);
        check_eq("sat_spike_idx", 32'(spike_idx), 2);
        check_eq("sat_state_zero", 32'(state_out), 0);

        // Refractory hold (or back-to-back spikes without it)
        do_reset();
        threshold = 8'd200;
        wr(2'd1, 8'd255);
        start();
        for (int k = 0; k < 4; k++) begin
`ifdef LIF_REFRACTORY_EN
            exp_sv = (k == 0 || k == 3);
`else
            exp_sv = 1'b1;
`endif
            run_to(spike_cyc[k]);
            check_eq("refrac_spike_valid", 32'(spike_valid), 32'(exp_sv));
            check_eq("refrac_state_zero", 32'(state_out), 0);
            if (exp_sv) check_eq("refrac_spike_idx", 32'(spike_idx), 1);
        end
        run_to(15);
        check_eq("refrac_no_spike_n2", 32'(spike_valid), 0);

        // Current write colliding with the update of the same neuron
        do_reset();
        threshold = 8'd255;
        start();
        run_to(4);
        cur_we = 1'b1; cur_addr = 2'd0; cur_data = 8'd100;
        step();
        cur_we = 1'b0;
        check_eq("coll_old_cur", 32'(state_out), 0);
        run_to(9);
        check_eq("coll_new_cur", 32'(state_out), 100);

        // en gating and frame_done
        do_reset();
        threshold = 8'd255;
        wr(2'd0, 8'd10);
        start();
        run_to(3);
        check_eq("frame_not_yet", 32'(frame_done), 0);
        run_to(4);
        check_eq("frame_done_4", 32'(frame_done), 1);
        run_to(5);
        check_eq("frame_pulse_ends", 32'(frame_done), 0);
        check_eq("gap_v0_before", 32'(state_out), 15);
        en = 1'b0;
        run_to(7);
        check_eq("gap_frame_low", 32'(frame_done), 0);
        check_eq("gap_state_hold", 32'(state_out), 15);
        run_to(8);
        en = 1'b1;
        check_eq("frame_done_8_suppressed", 32'(frame_done), 0);
        run_to(10);
        check_eq("frame_not_at_10", 32'(frame_done), 0);
        run_to(11);
        check_eq("frame_done_11", 32'(frame_done), 1);
        run_to(12);
        check_eq("gap_v0_after", 32'(state_out), 17);

        // Reset mid-frame
        do_reset();
        threshold = 8'd255;
        wr(2'd0, 8'd64);
        start();
        run_to(9);
        check_eq("midrst_v0_before", 32'(state_out), 112);
        run_to(10);
        rst = 1'b1;
        step();
        check_eq("midrst_spike_valid", 32'(spike_valid), 0);
        check_eq("midrst_spike_idx", 32'(spike_idx), 0);
        check_eq("midrst_frame_done", 32'(frame_done), 0);
        check_eq("midrst_state_out", 32'(state_out), 0);
        rst = 1'b0;
        en  = 1'b0;
        wr(2'd0, 8'd64);
        start();
        run_to(1);
        check_eq("midrst_restart_v0", 32'(state_out), 64);
        check_eq("midrst_restart_idx", 32'(spike_idx), 0);
        run_to(3);
        check_eq("midrst_frame_not_yet", 32'(frame_done), 0);
        run_to(4);
        check_eq("midrst_frame_done", 32'(frame_done), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
